commutation_ctrl: RTL
=====================

Name: commutation_ctrl

Overview:
Six-step commutation sequencer for the BLDC motor drive block. Synchronises the three hall sensors and maps them to the per-phase select codes (selGrn/selYlw/selBlu) and the 11-bit PWM duty. Mode changes (drive/brake/idle/fault) happen only at PWM period boundaries (PWM_synch), with a coast gap between drive and brake. Sits between the torque/assist logic (drv_mag, brake_n) and the motor drive block.

Parameters:
DEAD_PERIODS, 2, number of PWM periods all phases are held HIGH_Z when switching between drive and brake
BRAKE_DUTY, 11'h600, duty output while in BRAKE
STALL_PERIODS, 1024, PWM periods in DRIVE with no hall change before FAULT (only with STALL_DET_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (1 = reset on next clk edge)
hallGrn  in  1  asynchronous hall sensor, green phase
hallYlw  in  1  asynchronous hall sensor, yellow phase
hallBlu  in  1  asynchronous hall sensor, blue phase
brake_n  in  1  brake request, active-low, synchronous to clk
drv_mag  in  12  requested drive magnitude, 0 = no drive
PWM_synch  in  1  one-cycle pulse at each PWM period start, from the motor drive block
duty  out  11  PWM duty to the motor drive block
selGrn  out  2  green phase select
selYlw  out  2  yellow phase select
selBlu  out  2  blue phase select
fault  out  1  high while in FAULT
hall_err  out  1  registered, high when the sampled rotation state is 000 or 111

Behaviour:
- Select encoding: HIGH_Z=2'b00, REV_CURR=2'b01, FRWRD_CURR=2'b10, REGEN_BRAKE=2'b11.
- Hall path: each hall input passes through 2 flops. rot_state = {G,Y,B} is loaded from the synchronised values only on a cycle with PWM_synch=1.
- Drive table, rot_state -> {selGrn, selYlw, selBlu}:
  - 101 -> {FRWRD, REV, HIGH_Z}
  - 100 -> {FRWRD, HIGH_Z, REV}
  - 110 -> {HIGH_Z, FRWRD, REV}
  - 010 -> {REV, FRWRD, HIGH_Z}
  - 011 -> {REV, HIGH_Z, FRWRD}
  - 001 -> {HIGH_Z, REV, FRWRD}
- States: IDLE, DRIVE, COAST, BRAKE, FAULT. All transitions are evaluated only when PWM_synch=1.
- Priority at a PWM_synch: invalid hall > stall > brake > drv_mag.
  - IDLE: brake_n=0 -> COAST with target BRAKE; else drv_mag!=0 and valid hall -> DRIVE.
  - DRIVE: invalid hall (000/111) -> FAULT; stall -> FAULT; brake_n=0 -> COAST with target BRAKE; drv_mag==0 -> IDLE.
  - COAST: dead counter increments per PWM_synch; at DEAD_PERIODS -> target state, counter cleared.
  - BRAKE: brake_n=1 -> COAST with target IDLE.
  - FAULT: exit to IDLE only when drv_mag==0, brake_n=1 and the hall state is valid. Brake requests are ignored while in FAULT.
- Outputs are registered and reflect the state/rot_state from the previous cycle. Latency from PWM_synch sample to sel/duty change is 1 clk.
  - IDLE, COAST, FAULT: all sel = HIGH_Z, duty = 11'h400.
  - DRIVE: sel from the drive table; duty = 11'h400 + drv_mag[11:2]. The sum is 11 bits and cannot overflow (max 11'h7FF).
  - BRAKE: all sel = REGEN_BRAKE, duty = BRAKE_DUTY.
- Input changes between PWM_synch pulses are ignored; sel/duty never change mid-period.
- Reset (rst_n=1 at a clk edge):
  - state = IDLE, rot_state = 3'b000, synchronisers = 0, counters = 0.
  - duty = 11'h400, all sel = HIGH_Z, fault = 0, hall_err = 0.
  - Reset asserted mid-period or mid-COAST aborts immediately at that edge.

Optional Feature:
- Macro STALL_DET_EN.
- Defined: a stall counter is cleared whenever rot_state changes or the state is not DRIVE, and increments per PWM_synch in DRIVE. Reaching STALL_PERIODS -> FAULT. The counter saturates and does not wrap.
- Not defined: no stall counter exists; DRIVE leaves only on hall error, brake, or drv_mag==0.

Decomposition:
- Package commutation_pkg holds:
  - sel_t enum (HIGH_Z, REV_CURR, FRWRD_CURR, REGEN_BRAKE)
  - state_t enum
  - DUTY_MID = 11'h400
  - the six-entry drive-table function
- Sub-module hall_synch: triple 2-flop synchroniser plus the PWM_synch-gated rot_state register. Outputs rot_state and a one-cycle rot_changed pulse.

Test Plan:
- Reset, then drv_mag=12'h800, halls=101, PWM_synch pulse -> next pulse enters DRIVE; duty=11'h600, sel={10,01,00}.
- Step halls through 101,100,110,010,011,001 with one pulse each -> sel follows the table 1 clk after each pulse; no change between pulses.
- In DRIVE, brake_n=0 with DEAD_PERIODS=2 -> 2 periods of all 00 with duty 11'h400, then all 11 with duty 11'h600; brake_n=1 -> 2 periods of 00, then IDLE.
- Halls=111 in DRIVE -> next pulse: fault=1, hall_err=1, sel=00; stays in FAULT until drv_mag=0, halls valid and brake_n=1.
- With STALL_DET_EN and STALL_PERIODS=8: hold halls constant in DRIVE -> FAULT after the 8th pulse. Without the macro -> remains in DRIVE.
- Assert rst_n=1 mid-COAST -> next edge: IDLE, sel=00, duty=11'h400, fault=0.

Source files
------------

// File: rtl/commutation_pkg.sv
// Shared types and helpers for the commutation sequencer.
//   sel_t       per-phase select code driven to the motor drive block
//   state_t     sequencer operating modes
//   sel_bus_t   the three phase selects grouped as one payload
//   drive_table maps a rotation state onto the six-step phase selects
package commutation_pkg;

  localparam int unsigned DUTY_W = 11;
  localparam int unsigned MAG_W  = 12;
  localparam int unsigned HALL_W = 3;

  localparam logic [DUTY_W-1:0] DUTY_MID = 11'h400;

  typedef enum logic [1:0] {
    HIGH_Z      = 2'b00,
    REV_CURR    = 2'b01,
    FRWRD_CURR  = 2'b10,
    REGEN_BRAKE = 2'b11
  } sel_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_COAST = 3'd2,
    ST_BRAKE = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef struct packed {
    sel_t grn;
    sel_t ylw;
    sel_t blu;
  } sel_bus_t;

  // 000 and 111 cannot occur on a healthy sensor set
  function automatic logic hall_invalid(input logic [HALL_W-1:0] rot);
    return (rot == 3'b000) || (rot == 3'b111);
  endfunction

  // Six-step table; invalid codes leave every phase floating
  function automatic sel_bus_t drive_table(input logic [HALL_W-1:0] rot);
    sel_bus_t sel;
    sel = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
    case (rot)
      3'b101:  sel = '{grn: FRWRD_CURR, ylw: REV_CURR,   blu: HIGH_Z};
      3'b100:  sel = '{grn: FRWRD_CURR, ylw: HIGH_Z,     blu: REV_CURR};
      3'b110:  sel = '{grn: HIGH_Z,     ylw: FRWRD_CURR, blu: REV_CURR};
      3'b010:  sel = '{grn: REV_CURR,   ylw: FRWRD_CURR, blu: HIGH_Z};
      3'b011:  sel = '{grn: REV_CURR,   ylw: HIGH_Z,     blu: FRWRD_CURR};
      3'b001:  sel = '{grn: HIGH_Z,     ylw: REV_CURR,   blu: FRWRD_CURR};
      default: sel = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/commutation_ctrl_if.sv
// Bus between the torque/assist logic, the sequencer and the motor drive.
//   hallGrn/hallYlw/hallBlu  asynchronous hall sensors
//   brake_n                  brake request, active-low
//   drv_mag                  requested drive magnitude
//   PWM_synch                one-cycle pulse at each PWM period start
//   duty, selGrn/Ylw/Blu     PWM duty and phase selects to the motor drive
//   fault, hall_err          status flags
// master: stimulus side; slave: the sequencer.
interface commutation_ctrl_if;
  import commutation_pkg::*;

  logic              hallGrn;
  logic              hallYlw;
  logic              hallBlu;
  logic              brake_n;
  logic [MAG_W-1:0]  drv_mag;
  logic              PWM_synch;
  logic [DUTY_W-1:0] duty;
  sel_t              selGrn;
  sel_t              selYlw;
  sel_t              selBlu;
  logic              fault;
  logic              hall_err;

  modport master (
    output hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
    input  duty, selGrn, selYlw, selBlu, fault, hall_err
  );

  modport slave (
    input  hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
    output duty, selGrn, selYlw, selBlu, fault, hall_err
  );

endinterface

// File: rtl/commutation_ctrl_hall_synch.sv
// Hall sensor front end: 2-flop synchroniser per sensor, then the rotation
// state register that only loads on a PWM period boundary.
//   clk, rst_n    clock, synchronous active-high reset
//   hall_*        asynchronous hall inputs
//   pwm_synch     period-start pulse
//   rot_state     {G,Y,B} sampled at the last period start
//   rot_changed   one-cycle pulse after a load that changed rot_state
//   hall_err      registered: last sampled rotation state is 000 or 111
module commutation_ctrl_hall_synch
  import commutation_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hall_grn,
  input  logic              hall_ylw,
  input  logic              hall_blu,
  input  logic              pwm_synch,
  output logic [HALL_W-1:0] rot_state,
  output logic              rot_changed,
  output logic              hall_err
);

  logic [HALL_W-1:0] sync1_q, sync1_d;
  logic [HALL_W-1:0] sync2_q, sync2_d;
  logic [HALL_W-1:0] rot_q, rot_d;
  logic              rot_changed_q, rot_changed_d;
  logic              hall_err_q, hall_err_d;

  // Synchroniser chain and period-gated sample
  always_comb begin
    sync1_d       = {hall_grn, hall_ylw, hall_blu};
    sync2_d       = sync1_q;
    rot_d         = rot_q;
    hall_err_d    = hall_err_q;
    rot_changed_d = 1'b0;
    if (pwm_synch) begin
      rot_d         = sync2_q;
      hall_err_d    = hall_invalid(sync2_q);
      rot_changed_d = (sync2_q != rot_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      rot_q         <= '0;
      rot_changed_q <= 1'b0;
      hall_err_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rot_q         <= rot_d;
      rot_changed_q <= rot_changed_d;
      hall_err_q    <= hall_err_d;
    end
  end

  assign rot_state   = rot_q;
  assign rot_changed = rot_changed_q;
  assign hall_err    = hall_err_q;

endmodule

// File: rtl/commutation_ctrl.sv
// Six-step BLDC commutation sequencer. Maps synchronised hall states to
// phase selects and PWM duty; mode changes happen only at PWM period starts,
// with a coast gap of DEAD_PERIODS periods between drive and brake.
//   clk      system clock
//   rst_n    synchronous reset, active-HIGH despite the name
//   bus      commutation_ctrl_if.slave (halls, brake_n, drv_mag, PWM_synch in;
//            duty, selGrn/Ylw/Blu, fault, hall_err out)
// Optional: define STALL_DET_EN to fault after STALL_PERIODS periods in
// DRIVE without a hall change.
module commutation_ctrl
  import commutation_pkg::*;
#(
  parameter int unsigned       DEAD_PERIODS = 2,
  parameter logic [DUTY_W-1:0] BRAKE_DUTY   = 11'h600
`ifdef STALL_DET_EN
  , parameter int unsigned     STALL_PERIODS = 1024
`endif
) (
  input logic                clk,
  input logic                rst_n,
  commutation_ctrl_if.slave  bus
);

  localparam int unsigned DEAD_W = $clog2(DEAD_PERIODS + 1);
  localparam int unsigned MAGQ_W = MAG_W - 2;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS);

  logic [HALL_W-1:0] rot_state;
  logic              rot_changed;
  logic              hall_err;
  logic              rot_bad;
  logic              stall_hit;

  state_t            state_q, state_d;
  state_t            target_q, target_d;
  logic [DEAD_W-1:0] dead_q, dead_d, dead_inc;
  logic [MAGQ_W-1:0] mag_q, mag_d;

  logic [DUTY_W-1:0] duty_q, duty_d;
  sel_bus_t          sel_q, sel_d;
  logic              fault_q, fault_d;

  commutation_ctrl_hall_synch u_hall_synch (
    .clk         (clk),
    .rst_n       (rst_n),
    .hall_grn    (bus.hallGrn),
    .hall_ylw    (bus.hallYlw),
    .hall_blu    (bus.hallBlu),
    .pwm_synch   (bus.PWM_synch),
    .rot_state   (rot_state),
    .rot_changed (rot_changed),
    .hall_err    (hall_err)
  );

  assign rot_bad = hall_invalid(rot_state);

`ifdef STALL_DET_EN
  localparam int unsigned STALL_W = $clog2(STALL_PERIODS + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_PERIODS);

  logic [STALL_W-1:0] stall_q, stall_d, stall_inc;

  // Saturating count of periods spent in DRIVE since the last hall change
  always_comb begin
    stall_inc = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1);
    stall_d   = stall_q;
    if ((state_q != ST_DRIVE) || rot_changed) begin
      stall_d = '0;
    end else if (bus.PWM_synch) begin
      stall_d = stall_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_hit = (stall_inc == STALL_MAX);
`else
  logic unused_rot_changed;
  assign unused_rot_changed = rot_changed;
  assign stall_hit          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= ST_IDLE;
      dead_q   <= '0;
      mag_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dead_q   <= dead_d;
      mag_q    <= mag_d;
    end
  end

  // Next state; everything is held between period starts
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dead_d   = dead_q;
    mag_d    = mag_q;
    dead_inc = dead_q + DEAD_W'(1);
    if (bus.PWM_synch) begin
      mag_d = bus.drv_mag[MAG_W-1:2];
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.brake_n) begin
            state_d  = ST_COAST;
            target_d = ST_BRAKE;
          end else if ((bus.drv_mag != '0) && !rot_bad) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (rot_bad || stall_hit) begin
            state_d = ST_FAULT;
          end else if (!bus.brake_n) begin
            state_d  = ST_COAST;
            target_d = ST_BRAKE;
          end else if (bus.drv_mag == '0) begin
            state_d = ST_IDLE;
          end
        end
        ST_COAST: begin
          if (dead_inc == DEAD_LAST) begin
            state_d = target_q;
            dead_d  = '0;
          end else begin
            dead_d = dead_inc;
          end
        end
        ST_BRAKE: begin
          if (bus.brake_n) begin
            state_d  = ST_COAST;
            target_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          // brake requests are deliberately not honoured here
          if ((bus.drv_mag == '0) && bus.brake_n && !rot_bad) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    duty_d  = DUTY_MID;
    sel_d   = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
    fault_d = 1'b0;
    unique case (state_q)
      ST_DRIVE: begin
        sel_d  = drive_table(rot_state);
        duty_d = DUTY_MID + DUTY_W'(mag_q);
      end
      ST_BRAKE: begin
        sel_d  = '{grn: REGEN_BRAKE, ylw: REGEN_BRAKE, blu: REGEN_BRAKE};
        duty_d = BRAKE_DUTY;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      duty_q  <= DUTY_MID;
      sel_q   <= '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
      fault_q <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
    end
  end

  assign bus.duty     = duty_q;
  assign bus.selGrn   = sel_q.grn;
  assign bus.selYlw   = sel_q.ylw;
  assign bus.selBlu   = sel_q.blu;
  assign bus.fault    = fault_q;
  assign bus.hall_err = hall_err;

endmodule
